// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Default timing is 640x480@60 with active-low syncs.
package vga_timing_pkg;

  localparam int DEF_H_VA = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SP = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_VA = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SP = 2;
  localparam int DEF_V_BP = 33;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  function automatic int frame_total(int va, int fp, int sp, int bp);
    return va + fp + sp + bp;
  endfunction

  // Counter width able to hold 0..n-1.
  function automatic int cnt_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Modulo-N counter: advances on inc_i, wraps N-1 -> 0.
// wrap_o is high in the cycle where an increment takes the count back to zero.
module vga_timing_cnt
  import vga_timing_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = inc_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered sync/enable/position outputs.
// Define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt completed-frame counter port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VA    = DEF_H_VA,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SP    = DEF_H_SP,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VA    = DEF_V_VA,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SP    = DEF_V_SP,
  parameter int V_BP    = DEF_V_BP,
  parameter bit HS_POL  = POL_ACTIVE_LOW,
  parameter bit VS_POL  = POL_ACTIVE_LOW,
  parameter int FRAME_W = 8,
  localparam int H_TOTAL = frame_total(H_VA, H_FP, H_SP, H_BP),
  localparam int V_TOTAL = frame_total(V_VA, V_FP, V_SP, V_BP),
  localparam int HCW     = cnt_width(H_TOTAL),
  localparam int VCW     = cnt_width(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [HCW-1:0]     pix_x,
  output logic [VCW-1:0]     pix_y,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  if (H_VA < 1 || H_FP < 1 || H_SP < 1 || H_BP < 1 ||
      V_VA < 1 || V_FP < 1 || V_SP < 1 || V_BP < 1 || FRAME_W < 1) begin : g_bad_params
    $error("vga_timing_gen: all timing parameters and FRAME_W must be >= 1");
  end

  // Region boundaries sized to the counters; all are strictly below the totals.
  localparam logic [HCW-1:0] H_VIS_END = HCW'(H_VA);
  localparam logic [HCW-1:0] H_SYNC_LO = HCW'(H_VA + H_FP);
  localparam logic [HCW-1:0] H_SYNC_HI = HCW'(H_VA + H_FP + H_SP);
  localparam logic [VCW-1:0] V_VIS_END = VCW'(V_VA);
  localparam logic [VCW-1:0] V_SYNC_LO = VCW'(V_VA + V_FP);
  localparam logic [VCW-1:0] V_SYNC_HI = VCW'(V_VA + V_FP + V_SP);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap, v_wrap;

  vga_timing_cnt #(.N(H_TOTAL), .W(HCW)) u_h_cnt (
    .clk     (clk),
    .reset_i (reset),
    .inc_i   (en),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap)
  );

  vga_timing_cnt #(.N(V_TOTAL), .W(VCW)) u_v_cnt (
    .clk     (clk),
    .reset_i (reset),
    .inc_i   (h_wrap),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap)
  );

  logic de_d, hsync_d, vsync_d, line_start_d, frame_start_d;
  logic de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic [HCW-1:0] pix_x_q;
  logic [VCW-1:0] pix_y_q;

  always_comb begin
    de_d          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hsync_d       = ((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI)) ? HS_POL : !HS_POL;
    vsync_d       = ((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI)) ? VS_POL : !VS_POL;
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Strobes drop every cycle; levels only move on a pixel tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q          <= 1'b0;
      hsync_q       <= !HS_POL;
      vsync_q       <= !VS_POL;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (en) begin
        de_q          <= de_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        pix_x_q       <= h_cnt;
        pix_y_q       <= v_cnt;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
      end
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule
